// File: rtl/bus_chk_pkg.sv
// Shared types and helpers for the bus pattern checker.
// Checker FSM states and a saturating add used by the per-channel and total counters.
package bus_chk_pkg;

  typedef enum logic [1:0] {
    CHK_IDLE    = 2'd0,
    CHK_ARMED   = 2'd1,
    CHK_TRIPPED = 2'd2
  } chk_state_t;

  // Operands are zero-extended to 32 bits by the caller, so counters up to 32 bits wide are supported.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, inc};
    if (sum >= {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/bus_pattern_chk_ch.sv
// One monitored channel: violation detect, registered pulse, sticky flag,
// saturating error counter and capture of the first offending word.
module bus_pattern_chk_ch #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] MASK    = DATA_W'(32'h60),
  parameter logic [DATA_W-1:0] ILLEGAL = DATA_W'(32'h60),
  parameter bit                X_CHECK = 1'b1,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              chk_en_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              viol_o,
  output logic              err_pulse_o,
  output logic              err_sticky_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [DATA_W-1:0] first_data_o
);
  import bus_chk_pkg::*;

  localparam logic [DATA_W-1:0] ILL_M   = ILLEGAL & MASK;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [DATA_W-1:0] masked;
  logic              hit;

  logic              pulse_q,  pulse_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [DATA_W-1:0] first_q,  first_d;

  assign masked = data_i & MASK;

  always_comb begin
    hit = (masked === ILL_M);
`ifndef SYNTHESIS
    // Unknown masked bits count as a violation when X checking is enabled.
    if (X_CHECK && ((^masked) === 1'bx)) begin
      hit = 1'b1;
    end
`endif
  end

  assign viol_o = chk_en_i & valid_i & hit;

  always_comb begin
    pulse_d  = viol_o;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    if (viol_o) begin
      sticky_d = 1'b1;
      cnt_d    = CNT_W'(sat_inc(32'(cnt_q), 32'd1, 32'(CNT_MAX)));
      if (!sticky_q) begin
        first_d = data_i;
      end
    end
    if (clr_i) begin
      pulse_d  = 1'b0;
      sticky_d = 1'b0;
      cnt_d    = '0;
      first_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      first_q  <= '0;
    end else begin
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
    end
  end

  assign err_pulse_o  = pulse_q;
  assign err_sticky_o = sticky_q;
  assign err_cnt_o    = cnt_q;
  assign first_data_o = first_q;

endmodule

// File: rtl/bus_pattern_checker.sv
// Multi-channel bus legality monitor: per-channel checkers plus a shared
// trip FSM that fires once the total violation count reaches ERR_LIMIT.
//
// state       | meaning
// CHK_IDLE    | checking disabled, nothing recorded
// CHK_ARMED   | recording violations, total below ERR_LIMIT
// CHK_TRIPPED | limit reached; counting continues, trip outputs frozen
module bus_pattern_checker #(
  parameter int                DATA_W        = 32,
  parameter int                NUM_CH        = 2,
  parameter logic [DATA_W-1:0] MASK          = DATA_W'(32'h60),
  parameter logic [DATA_W-1:0] ILLEGAL       = DATA_W'(32'h60),
  parameter bit                X_CHECK       = 1'b1,
  parameter int                CNT_W         = 16,
  parameter int                ERR_LIMIT     = 3,
  parameter bit                FATAL_ON_TRIP = 1'b0,
  localparam int               CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        err_pulse,
  output logic [NUM_CH-1:0]        err_sticky,
  output logic [NUM_CH*CNT_W-1:0]  err_cnt,
  output logic [NUM_CH*DATA_W-1:0] first_err_data,
  output logic                     tripped,
  output logic [CH_W-1:0]          tripped_ch
);
  import bus_chk_pkg::*;

  localparam int TOT_W = $clog2(ERR_LIMIT + 1);

  chk_state_t        state_q, state_d;
  logic [TOT_W-1:0]  total_q, total_d;
  logic              tripped_q, tripped_d;
  logic [CH_W-1:0]   tch_q, tch_d;

  logic              chk_en;
  logic [NUM_CH-1:0] viol;
  logic [31:0]       viol_cnt;
  logic [31:0]       tot_sum;
  logic [CH_W-1:0]   low_idx;

  assign chk_en = en & (state_q != CHK_IDLE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    bus_pattern_chk_ch #(
      .DATA_W  (DATA_W),
      .MASK    (MASK),
      .ILLEGAL (ILLEGAL),
      .X_CHECK (X_CHECK),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_i        (rst),
      .clr_i        (clr),
      .chk_en_i     (chk_en),
      .valid_i      (ch_valid[g]),
      .data_i       (ch_data[g*DATA_W +: DATA_W]),
      .viol_o       (viol[g]),
      .err_pulse_o  (err_pulse[g]),
      .err_sticky_o (err_sticky[g]),
      .err_cnt_o    (err_cnt[g*CNT_W +: CNT_W]),
      .first_data_o (first_err_data[g*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    viol_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      viol_cnt = viol_cnt + 32'(viol[i]);
    end
  end

  // Scan from the top so the lowest violating index wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (viol[i]) begin
        low_idx = CH_W'(i);
      end
    end
  end

  assign tot_sum = sat_inc(32'(total_q), viol_cnt, 32'(ERR_LIMIT));

  always_comb begin
    state_d   = state_q;
    total_d   = TOT_W'(tot_sum);
    tripped_d = tripped_q;
    tch_d     = tch_q;
    case (state_q)
      CHK_IDLE: begin
        if (en) begin
          state_d = CHK_ARMED;
        end
      end
      CHK_ARMED: begin
        if (!en) begin
          state_d = CHK_IDLE;
        end else if (tot_sum >= 32'(ERR_LIMIT)) begin
          state_d   = CHK_TRIPPED;
          tripped_d = 1'b1;
          tch_d     = low_idx;
        end
      end
      CHK_TRIPPED: begin
        state_d = CHK_TRIPPED;
      end
      default: begin
        state_d = CHK_IDLE;
      end
    endcase
    if (clr) begin
      state_d   = en ? CHK_ARMED : CHK_IDLE;
      total_d   = '0;
      tripped_d = 1'b0;
      tch_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CHK_IDLE;
      total_q   <= '0;
      tripped_q <= 1'b0;
      tch_q     <= '0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      tripped_q <= tripped_d;
      tch_q     <= tch_d;
    end
  end

  assign tripped    = tripped_q;
  assign tripped_ch = tch_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (FATAL_ON_TRIP && !rst && state_q == CHK_ARMED && state_d == CHK_TRIPPED) begin
      $display("BUS-CHK ERROR ch=%0d data=%h", low_idx, ch_data[low_idx*DATA_W +: DATA_W]);
      $finish;
    end
  end
`endif

endmodule
